// File: rtl/parking_fee_fifo.sv
// parking_fee_fifo: circular entry-timestamp FIFO with registered duration/fee on each accepted exit
module parking_fee_fifo #(
    parameter int TIME_WIDTH = 16,
    parameter int COST_WIDTH = 16,
    parameter int RATE_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int MIN_FEE    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         entry,
    input  logic                         exit,
    input  logic [TIME_WIDTH-1:0]        global_time,
    input  logic [RATE_WIDTH-1:0]        rate,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         empty,
    output logic                         fee_valid,
    output logic [TIME_WIDTH-1:0]        duration,
    output logic [COST_WIDTH-1:0]        fee,
    output logic                         entry_rejected,
    output logic                         exit_rejected
);
    localparam int OW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = TIME_WIDTH + RATE_WIDTH;
    localparam int XW = PW > COST_WIDTH ? PW : COST_WIDTH;
    localparam logic [PW-1:0] MIN_P = PW'(MIN_FEE);
    localparam logic [XW-1:0] COST_MAX = XW'({COST_WIDTH{1'b1}});

    logic [TIME_WIDTH-1:0] slot [DEPTH];
    logic [AW-1:0] head, tail, head_next, tail_next;
    logic [OW-1:0] occ_next;
    logic exit_acc, entry_acc;
    logic [TIME_WIDTH-1:0] d;
    logic [PW-1:0] p, q;
    logic [XW-1:0] qx;
    logic [COST_WIDTH-1:0] fee_next;

    always_comb begin
        exit_acc  = exit & ~empty;
        entry_acc = entry & (~full | exit_acc);
        head_next = head == AW'(DEPTH-1) ? '0 : head + AW'(1);
        tail_next = tail == AW'(DEPTH-1) ? '0 : tail + AW'(1);
        occ_next  = entry_acc == exit_acc ? occupancy : entry_acc ? occupancy + OW'(1) : occupancy - OW'(1);
        // modular subtraction makes a wrapped global_time come out right
        d         = global_time - slot[head];
        p         = {{RATE_WIDTH{1'b0}}, d} * {{TIME_WIDTH{1'b0}}, rate};
        q         = p < MIN_P ? MIN_P : p;
        qx        = XW'(q);
        fee_next  = qx > COST_MAX ? '1 : COST_WIDTH'(qx);
    end

    always_ff @(posedge clk) begin
        if (!rst && entry_acc) slot[tail] <= global_time;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            occupancy      <= '0;
            full           <= 1'b0;
            empty          <= 1'b1;
            fee_valid      <= 1'b0;
            duration       <= '0;
            fee            <= '0;
            entry_rejected <= 1'b0;
            exit_rejected  <= 1'b0;
        end else begin
            if (entry_acc) tail <= tail_next;
            if (exit_acc) begin
                head     <= head_next;
                duration <= d;
                fee      <= fee_next;
            end
            occupancy      <= occ_next;
            full           <= occ_next == OW'(DEPTH);
            empty          <= occ_next == '0;
            fee_valid      <= exit_acc;
            entry_rejected <= entry & ~entry_acc;
            exit_rejected  <= exit & empty;
        end
    end
endmodule
